bcd_countdown_timer: RTL and testbench
======================================

# bcd_countdown_timer

Four-digit BCD countdown timer (MM:SS, 00:00–99:59) that consumes the single-cycle 1 Hz enable produced by the counter/divider chain and decrements once per tick. It sits between the tick generator and the display/alarm logic. The display digits are always readable, and a one-cycle `done` pulse marks expiry.

## Interface
- No parameters. Digit count and moduli are fixed by the MM:SS format.
- `sys_clk  in  1` system clock; all logic on the rising edge.
- `sys_rst  in  1` synchronous, active-high reset.
- `tick_1hz  in  1` one-cycle enable, asserted once per second.
- `clear  in  1` synchronous return to IDLE with value 00:00.
- `load  in  1` load request for `load_val`.
- `load_val  in  16` BCD `{min_tens, min_ones, sec_tens, sec_ones}`.
- `start  in  1` start from IDLE, or resume from PAUSE.
- `pause  in  1` pause while RUN.
- `time_bcd  out  16` current value, same packing as `load_val`.
- `running  out  1` high while in RUN.
- `done  out  1` one-cycle expiry pulse.
- `load_err  out  1` one-cycle pulse when a load is rejected.

## Operation
- **States:** IDLE, RUN, PAUSE, DONE.
- **Input priority:** `sys_rst` > `clear` > `load` > `start` / `pause` > `tick_1hz`.
- **`clear`:** from any state, go to IDLE; `time_bcd` and the reload register become 0.
- **`load`:**
  - Accepted in IDLE, PAUSE and DONE; ignored in RUN (no error).
  - Valid when every digit is ≤9 and `sec_tens` is ≤5.
  - A valid load writes `time_bcd` and the reload register, and the state goes to IDLE.
  - An invalid load pulses `load_err`; value and state are unchanged.
- **`start`:**
  - In IDLE or PAUSE with `time_bcd` ≠ 0: go to RUN.
  - With `time_bcd` = 0: ignored.
  - Ignored in RUN and DONE.
- **`pause`:** in RUN, go to PAUSE; ignored in all other states. If `start` and `pause` arrive together in RUN, `pause` takes effect.
- **Decrement:** only in RUN, and only on a `tick_1hz` cycle in which no higher-priority input acts.
  - `sec_ones` 9→0 borrows from `sec_tens`.
  - `sec_tens` 5→0 borrows from `min_ones`.
  - `min_ones` 9→0 borrows from `min_tens`.
  - Example: 10:00 → 09:59.
- **Expiry:** a decrement from 00:01 to 00:00 pulses `done` and moves to DONE. 00:00 never wraps to 99:59.
- **DONE:** holds 00:00 until `clear`, a valid `load`, or reset.

## Timing
- **Reset values:** `time_bcd` = 16'h0000, `running` = 0, `done` = 0, `load_err` = 0, reload register = 0, state IDLE.
- **Latency:** all outputs are registered; each input takes effect on the edge where it is sampled and is visible one cycle later.
- `done` goes high in the same cycle that `time_bcd` first reads 16'h0000. It stays high exactly one cycle.
- A `tick_1hz` in the same cycle as `start` is not consumed; the first decrement happens on the next tick.
- A `tick_1hz` in the same cycle as `pause`, `load` or `clear` is dropped.
- Back-to-back ticks on consecutive cycles each decrement; the bench uses this to speed up simulation.
- `sys_rst` asserted mid-RUN returns the block to its reset values on the next edge, regardless of other inputs.

## Configuration
- **`BCD_TIMER_AUTO_RELOAD_EN` defined:** on expiry, `time_bcd` is reloaded from the reload register in the same edge and the state stays RUN.
  - `done` still pulses for one cycle.
  - `time_bcd` never shows 00:00 unless the reload value is 0.
  - A reload value of 0 behaves as if the macro were undefined.
- **Not defined:** no reload register is synthesized; expiry always goes to DONE.

## Structure
- **`timer_pkg`:**
  - State enum `timer_state_t` (IDLE, RUN, PAUSE, DONE).
  - Digit moduli constants `SEC_ONES_MAX` = 9, `SEC_TENS_MAX` = 5, `MIN_ONES_MAX` = 9, `MIN_TENS_MAX` = 9.
  - BCD validity function.
- **Sub-module `bcd_digit_down`:**
  - Parameter: digit maximum.
  - Inputs: `dec`, `load`, `load_digit`, `clr`.
  - Outputs: `digit[3:0]` and a combinational `borrow` (high when `digit` = 0).
  - Four instances form the borrow chain; the top level holds the FSM, validity check and output pulses.

## Test plan
- Load 16'h0100, `start`, apply 1 tick → `time_bcd` = 16'h0059; after 59 more ticks → 16'h0000 with `done` high for one cycle, then state DONE and `running` = 0.
- Load 16'h1000, `start`, apply 1 tick → 16'h0959; load 16'h9959 and apply ticks through 99:00 → 98:59.
- Load 16'h0070 (`sec_tens` = 7) while in IDLE holding 00:05 → `load_err` pulses once and `time_bcd` stays 16'h0005; load while RUN → ignored, no `load_err`.
- In RUN at 00:30, assert `pause` together with `tick_1hz` → value stays 00:30 and state PAUSE; then `start` together with a tick → value 00:30, RUN; the next tick gives 00:29.
- With `BCD_TIMER_AUTO_RELOAD_EN`, load 16'h0003 and start, apply 3 ticks → `done` pulses and `time_bcd` = 16'h0003, still RUN; without the macro → DONE at 00:00.
- Assert `sys_rst` at 00:42 in RUN, together with `load` and `tick_1hz` → next cycle `time_bcd` = 0, IDLE, all pulses low.

Source files
------------

// File: rtl/timer_pkg.sv
// Shared types, digit moduli and the BCD time validity helper for the
// MM:SS countdown timer.
package timer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2,
        ST_DONE  = 2'd3
    } timer_state_t;

    localparam logic [3:0] SEC_ONES_MAX = 4'd9;
    localparam logic [3:0] SEC_TENS_MAX = 4'd5;
    localparam logic [3:0] MIN_ONES_MAX = 4'd9;
    localparam logic [3:0] MIN_TENS_MAX = 4'd9;

    // True when every digit of {min_tens, min_ones, sec_tens, sec_ones} is in range.
    function automatic logic bcd_time_valid(input logic [15:0] value);
        return (value[15:12] <= MIN_TENS_MAX) &&
               (value[11:8]  <= MIN_ONES_MAX) &&
               (value[7:4]   <= SEC_TENS_MAX) &&
               (value[3:0]   <= SEC_ONES_MAX);
    endfunction

endpackage

// File: rtl/bcd_digit_down.sv
// One BCD down-counting digit. Wraps 0 -> DIGIT_MAX on a decrement and
// reports a combinational borrow while the digit reads 0, so the next
// digit up the chain can be enabled.
module bcd_digit_down #(
    parameter logic [3:0] DIGIT_MAX = 4'd9
) (
    input  logic       sys_clk,
    input  logic       sys_rst,
    input  logic       dec,
    input  logic       load,
    input  logic [3:0] load_digit,
    input  logic       clr,
    output logic [3:0] digit,
    output logic       borrow
);

    logic [3:0] digit_r;

    // Digit register: reset > clear > load > decrement.
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            digit_r <= 4'd0;
        end else if (clr) begin
            digit_r <= 4'd0;
        end else if (load) begin
            digit_r <= load_digit;
        end else if (dec) begin
            if (digit_r == 4'd0) begin
                digit_r <= DIGIT_MAX;
            end else begin
                digit_r <= digit_r - 4'd1;
            end
        end else begin
            digit_r <= digit_r;
        end
    end

    assign digit  = digit_r;
    assign borrow = (digit_r == 4'd0);

endmodule

// File: rtl/bcd_countdown_timer.sv
// Four-digit MM:SS BCD countdown timer driven by a 1 Hz enable.
// Holds the IDLE/RUN/PAUSE/DONE control FSM, load validation and the
// registered done / load_err pulses; the digits live in bcd_digit_down.
// Optional feature: define BCD_TIMER_AUTO_RELOAD_EN to reload the last
// loaded value on expiry and keep running.
module bcd_countdown_timer
    import timer_pkg::*;
(
    input  logic        sys_clk,
    input  logic        sys_rst,
    input  logic        tick_1hz,
    input  logic        clear,
    input  logic        load,
    input  logic [15:0] load_val,
    input  logic        start,
    input  logic        pause,
    output logic [15:0] time_bcd,
    output logic        running,
    output logic        done,
    output logic        load_err
);

    timer_state_t state_r;
    timer_state_t state_nx_s;
    logic         dig_clr_s;
    logic         dig_load_s;
    logic [15:0]  load_data_s;
    logic         dec_s;
    logic         done_nx_s;
    logic         err_nx_s;
    logic [15:0]  time_s;
    logic [3:0]   borrow_s;
    logic [3:0]   dig_dec_s;
    logic         time_zero_s;
    logic         time_one_s;
    logic         running_r;
    logic         done_r;
    logic         load_err_r;

`ifdef BCD_TIMER_AUTO_RELOAD_EN
    logic [15:0]  reload_r;
    logic         reload_we_s;
    logic         reload_clr_s;
`endif

    assign time_zero_s = (time_s == 16'h0000);
    assign time_one_s  = (time_s == 16'h0001);

    // Borrow chain: a digit steps only when every lower digit is at 0.
    assign dig_dec_s[0] = dec_s;
    assign dig_dec_s[1] = dig_dec_s[0] & borrow_s[0];
    assign dig_dec_s[2] = dig_dec_s[1] & borrow_s[1];
    assign dig_dec_s[3] = dig_dec_s[2] & borrow_s[2];

    bcd_digit_down #(.DIGIT_MAX(SEC_ONES_MAX)) u_sec_ones (
        .sys_clk(sys_clk), .sys_rst(sys_rst), .dec(dig_dec_s[0]), .load(dig_load_s),
        .load_digit(load_data_s[3:0]), .clr(dig_clr_s), .digit(time_s[3:0]), .borrow(borrow_s[0])
    );
    bcd_digit_down #(.DIGIT_MAX(SEC_TENS_MAX)) u_sec_tens (
        .sys_clk(sys_clk), .sys_rst(sys_rst), .dec(dig_dec_s[1]), .load(dig_load_s),
        .load_digit(load_data_s[7:4]), .clr(dig_clr_s), .digit(time_s[7:4]), .borrow(borrow_s[1])
    );
    bcd_digit_down #(.DIGIT_MAX(MIN_ONES_MAX)) u_min_ones (
        .sys_clk(sys_clk), .sys_rst(sys_rst), .dec(dig_dec_s[2]), .load(dig_load_s),
        .load_digit(load_data_s[11:8]), .clr(dig_clr_s), .digit(time_s[11:8]), .borrow(borrow_s[2])
    );
    bcd_digit_down #(.DIGIT_MAX(MIN_TENS_MAX)) u_min_tens (
        .sys_clk(sys_clk), .sys_rst(sys_rst), .dec(dig_dec_s[3]), .load(dig_load_s),
        .load_digit(load_data_s[15:12]), .clr(dig_clr_s), .digit(time_s[15:12]), .borrow(borrow_s[3])
    );

    // Next-state and digit control, in input priority order clear > load > start/pause > tick.
    always_comb begin
        state_nx_s  = state_r;
        dig_clr_s   = 1'b0;
        dig_load_s  = 1'b0;
        load_data_s = load_val;
        dec_s       = 1'b0;
        done_nx_s   = 1'b0;
        err_nx_s    = 1'b0;
`ifdef BCD_TIMER_AUTO_RELOAD_EN
        reload_we_s  = 1'b0;
        reload_clr_s = 1'b0;
`endif
        if (clear) begin
            state_nx_s = ST_IDLE;
            dig_clr_s  = 1'b1;
`ifdef BCD_TIMER_AUTO_RELOAD_EN
            reload_clr_s = 1'b1;
`endif
        end else if (load && (state_r != ST_RUN)) begin
            if (bcd_time_valid(load_val)) begin
                state_nx_s = ST_IDLE;
                dig_load_s = 1'b1;
`ifdef BCD_TIMER_AUTO_RELOAD_EN
                reload_we_s = 1'b1;
`endif
            end else begin
                err_nx_s = 1'b1;
            end
        end else begin
            case (state_r)
                ST_IDLE, ST_PAUSE: begin
                    // A tick in the start cycle is deliberately not consumed.
                    if (start && !time_zero_s) begin
                        state_nx_s = ST_RUN;
                    end else begin
                        state_nx_s = state_r;
                    end
                end
                ST_RUN: begin
                    if (pause) begin
                        state_nx_s = ST_PAUSE;
                    end else if (tick_1hz) begin
                        if (time_one_s) begin
                            done_nx_s = 1'b1;
`ifdef BCD_TIMER_AUTO_RELOAD_EN
                            if (reload_r != 16'h0000) begin
                                dig_load_s  = 1'b1;
                                load_data_s = reload_r;
                                state_nx_s  = ST_RUN;
                            end else begin
                                dec_s      = 1'b1;
                                state_nx_s = ST_DONE;
                            end
`else
                            dec_s      = 1'b1;
                            state_nx_s = ST_DONE;
`endif
                        end else if (time_zero_s) begin
                            // Never wrap 00:00 to 99:59.
                            state_nx_s = ST_DONE;
                        end else begin
                            dec_s = 1'b1;
                        end
                    end else begin
                        state_nx_s = ST_RUN;
                    end
                end
                ST_DONE: begin
                    state_nx_s = ST_DONE;
                end
                default: begin
                    state_nx_s = ST_IDLE;
                end
            endcase
        end
    end

    // State register and registered status outputs.
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state_r    <= ST_IDLE;
            running_r  <= 1'b0;
            done_r     <= 1'b0;
            load_err_r <= 1'b0;
        end else begin
            state_r    <= state_nx_s;
            running_r  <= (state_nx_s == ST_RUN);
            done_r     <= done_nx_s;
            load_err_r <= err_nx_s;
        end
    end

`ifdef BCD_TIMER_AUTO_RELOAD_EN
    // Reload register: captures each accepted load, cleared with the timer.
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            reload_r <= 16'h0000;
        end else if (reload_clr_s) begin
            reload_r <= 16'h0000;
        end else if (reload_we_s) begin
            reload_r <= load_val;
        end else begin
            reload_r <= reload_r;
        end
    end
`endif

    assign time_bcd = time_s;
    assign running  = running_r;
    assign done     = done_r;
    assign load_err = load_err_r;

endmodule

// File: tb/tb_bcd_countdown_timer.sv
// Self-checking bench for bcd_countdown_timer: hand-written countdown
// sequences plus a vector table, checked through an expectation queue.
// Expectations follow BCD_TIMER_AUTO_RELOAD_EN when it is defined.
module tb_bcd_countdown_timer;

    logic        sys_clk = 1'b0;
    logic        sys_rst = 1'b0;
    logic        tick_1hz = 1'b0;
    logic        clear = 1'b0;
    logic        load = 1'b0;
    logic [15:0] load_val = 16'h0000;
    logic        start = 1'b0;
    logic        pause = 1'b0;
    logic [15:0] time_bcd;
    logic        running;
    logic        done;
    logic        load_err;

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        string       name;
        logic        rst;
        logic        clr;
        logic        ld;
        logic [15:0] lv;
        logic        st;
        logic        pa;
        logic        tk;
        logic [15:0] e_time;
        logic        e_run;
        logic        e_done;
        logic        e_err;
    } vec_t;

    vec_t exp_q[$];
    vec_t tbl[$];

    bcd_countdown_timer dut (
        .sys_clk(sys_clk), .sys_rst(sys_rst), .tick_1hz(tick_1hz), .clear(clear),
        .load(load), .load_val(load_val), .start(start), .pause(pause),
        .time_bcd(time_bcd), .running(running), .done(done), .load_err(load_err)
    );

    always #5 sys_clk = ~sys_clk;

    function automatic vec_t mk(input string nm, input logic rst, input logic clr, input logic ld,
                                input logic [15:0] lv, input logic st, input logic pa, input logic tk,
                                input logic [15:0] et, input logic er, input logic ed, input logic ee);
        vec_t v;
        v.name = nm; v.rst = rst; v.clr = clr; v.ld = ld; v.lv = lv;
        v.st = st; v.pa = pa; v.tk = tk;
        v.e_time = et; v.e_run = er; v.e_done = ed; v.e_err = ee;
        return v;
    endfunction

    // Reference decrement done in whole seconds rather than digit borrows.
    function automatic logic [15:0] bcd_dec(input logic [15:0] t);
        int secs;
        int m;
        int s;
        logic [15:0] r;
        secs = (int'(t[15:12]) * 10 + int'(t[11:8])) * 60 + int'(t[7:4]) * 10 + int'(t[3:0]) - 1;
        m = secs / 60;
        s = secs % 60;
        r = {4'(m / 10), 4'(m % 10), 4'(s / 10), 4'(s % 10)};
        return r;
    endfunction

    task automatic check_out();
        vec_t e;
        e = exp_q.pop_front();
        n_cmp++;
        if (time_bcd !== e.e_time) begin
            n_bad++;
            $display("FAIL %s time_bcd: got %h expected %h", e.name, time_bcd, e.e_time);
        end
        n_cmp++;
        if (running !== e.e_run) begin
            n_bad++;
            $display("FAIL %s running: got %b expected %b", e.name, running, e.e_run);
        end
        n_cmp++;
        if (done !== e.e_done) begin
            n_bad++;
            $display("FAIL %s done: got %b expected %b", e.name, done, e.e_done);
        end
        n_cmp++;
        if (load_err !== e.e_err) begin
            n_bad++;
            $display("FAIL %s load_err: got %b expected %b", e.name, load_err, e.e_err);
        end
    endtask

    task automatic run_vec(input vec_t v);
        sys_rst  = v.rst;
        clear    = v.clr;
        load     = v.ld;
        load_val = v.lv;
        start    = v.st;
        pause    = v.pa;
        tick_1hz = v.tk;
        exp_q.push_back(v);
        @(posedge sys_clk);
        #1;
        check_out();
    endtask

    initial begin
        logic [15:0] exp_t;

        // Table of single-cycle corner cases, applied after the long countdowns.
        tbl.push_back(mk("clear",        1'b0, 1'b1, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0));
        tbl.push_back(mk("start_zero",   1'b0, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0));
        tbl.push_back(mk("load_0005",    1'b0, 1'b0, 1'b1, 16'h0005, 1'b0, 1'b0, 1'b0, 16'h0005, 1'b0, 1'b0, 1'b0));
        tbl.push_back(mk("load_bad_st",  1'b0, 1'b0, 1'b1, 16'h0070, 1'b0, 1'b0, 1'b0, 16'h0005, 1'b0, 1'b0, 1'b1));
        tbl.push_back(mk("err_clears",   1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 16'h0005, 1'b0, 1'b0, 1'b0));
        tbl.push_back(mk("start_5",      1'b0, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b0, 16'h0005, 1'b1, 1'b0, 1'b0));
        tbl.push_back(mk("load_in_run",  1'b0, 1'b0, 1'b1, 16'h0123, 1'b0, 1'b0, 1'b0, 16'h0005, 1'b1, 1'b0, 1'b0));
        tbl.push_back(mk("pause_5",      1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b1, 1'b0, 16'h0005, 1'b0, 1'b0, 1'b0));
        tbl.push_back(mk("load_0030",    1'b0, 1'b0, 1'b1, 16'h0030, 1'b0, 1'b0, 1'b0, 16'h0030, 1'b0, 1'b0, 1'b0));
        tbl.push_back(mk("start_30",     1'b0, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b0, 16'h0030, 1'b1, 1'b0, 1'b0));
        tbl.push_back(mk("pause_tick",   1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b1, 1'b1, 16'h0030, 1'b0, 1'b0, 1'b0));
        tbl.push_back(mk("load_bad_mt",  1'b0, 1'b0, 1'b1, 16'h0A00, 1'b0, 1'b0, 1'b0, 16'h0030, 1'b0, 1'b0, 1'b1));
        tbl.push_back(mk("start_tick",   1'b0, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1, 16'h0030, 1'b1, 1'b0, 1'b0));
        tbl.push_back(mk("tick_29",      1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b1, 16'h0029, 1'b1, 1'b0, 1'b0));
        tbl.push_back(mk("st_pa_tick",   1'b0, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b1, 16'h0029, 1'b0, 1'b0, 1'b0));
        tbl.push_back(mk("resume_29",    1'b0, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b0, 16'h0029, 1'b1, 1'b0, 1'b0));
        tbl.push_back(mk("pause_29",     1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b1, 1'b0, 16'h0029, 1'b0, 1'b0, 1'b0));
        tbl.push_back(mk("load_0042",    1'b0, 1'b0, 1'b1, 16'h0042, 1'b0, 1'b0, 1'b0, 16'h0042, 1'b0, 1'b0, 1'b0));
        tbl.push_back(mk("start_42",     1'b0, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b0, 16'h0042, 1'b1, 1'b0, 1'b0));
        tbl.push_back(mk("rst_mid_run",  1'b1, 1'b0, 1'b1, 16'h1234, 1'b0, 1'b0, 1'b1, 16'h0000, 1'b0, 1'b0, 1'b0));
        tbl.push_back(mk("start_after",  1'b0, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0));
        tbl.push_back(mk("load_0003",    1'b0, 1'b0, 1'b1, 16'h0003, 1'b0, 1'b0, 1'b0, 16'h0003, 1'b0, 1'b0, 1'b0));
        tbl.push_back(mk("start_3",      1'b0, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b0, 16'h0003, 1'b1, 1'b0, 1'b0));
        tbl.push_back(mk("tick_2",       1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b1, 16'h0002, 1'b1, 1'b0, 1'b0));
        tbl.push_back(mk("tick_1",       1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b1, 16'h0001, 1'b1, 1'b0, 1'b0));
`ifdef BCD_TIMER_AUTO_RELOAD_EN
        tbl.push_back(mk("expire_rld",   1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b1, 16'h0003, 1'b1, 1'b1, 1'b0));
        tbl.push_back(mk("after_rld",    1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b1, 16'h0002, 1'b1, 1'b0, 1'b0));
        tbl.push_back(mk("start_rld",    1'b0, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b0, 16'h0002, 1'b1, 1'b0, 1'b0));
        tbl.push_back(mk("load_run_rld", 1'b0, 1'b0, 1'b1, 16'h0010, 1'b0, 1'b0, 1'b0, 16'h0002, 1'b1, 1'b0, 1'b0));
`else
        tbl.push_back(mk("expire",       1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b1, 16'h0000, 1'b0, 1'b1, 1'b0));
        tbl.push_back(mk("done_hold",    1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b1, 16'h0000, 1'b0, 1'b0, 1'b0));
        tbl.push_back(mk("start_done",   1'b0, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0));
        tbl.push_back(mk("load_done",    1'b0, 1'b0, 1'b1, 16'h0010, 1'b0, 1'b0, 1'b0, 16'h0010, 1'b0, 1'b0, 1'b0));
`endif
        tbl.push_back(mk("final_clear",  1'b0, 1'b1, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b1, 16'h0000, 1'b0, 1'b0, 1'b0));

        // Reset state.
        run_vec(mk("reset_0", 1'b1, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0));
        run_vec(mk("reset_1", 1'b1, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0));

        // 01:00 counts down to expiry.
        run_vec(mk("load_0100", 1'b0, 1'b0, 1'b1, 16'h0100, 1'b0, 1'b0, 1'b0, 16'h0100, 1'b0, 1'b0, 1'b0));
        run_vec(mk("start_100", 1'b0, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b0, 16'h0100, 1'b1, 1'b0, 1'b0));
        run_vec(mk("tick_0059", 1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b1, 16'h0059, 1'b1, 1'b0, 1'b0));
        exp_t = 16'h0059;
        for (int i = 0; i < 58; i++) begin
            exp_t = bcd_dec(exp_t);
            run_vec(mk("count_down", 1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b1, exp_t, 1'b1, 1'b0, 1'b0));
        end
`ifdef BCD_TIMER_AUTO_RELOAD_EN
        run_vec(mk("expire_100", 1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b1, 16'h0100, 1'b1, 1'b1, 1'b0));
        run_vec(mk("pause_100",  1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b1, 1'b0, 16'h0100, 1'b0, 1'b0, 1'b0));
`else
        run_vec(mk("expire_100", 1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b1, 16'h0000, 1'b0, 1'b1, 1'b0));
        run_vec(mk("done_1cyc",  1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0));
        run_vec(mk("start_dn",   1'b0, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0));
`endif

        // 10:00 -> 09:59, then 99:59 down across the minute borrow to 98:59.
        run_vec(mk("load_1000",  1'b0, 1'b0, 1'b1, 16'h1000, 1'b0, 1'b0, 1'b0, 16'h1000, 1'b0, 1'b0, 1'b0));
        run_vec(mk("start_1000", 1'b0, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b0, 16'h1000, 1'b1, 1'b0, 1'b0));
        run_vec(mk("tick_0959",  1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b1, 16'h0959, 1'b1, 1'b0, 1'b0));
        run_vec(mk("ld_ign_run", 1'b0, 1'b0, 1'b1, 16'h9959, 1'b0, 1'b0, 1'b0, 16'h0959, 1'b1, 1'b0, 1'b0));
        run_vec(mk("pause_959",  1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b1, 1'b0, 16'h0959, 1'b0, 1'b0, 1'b0));
        run_vec(mk("load_9959",  1'b0, 1'b0, 1'b1, 16'h9959, 1'b0, 1'b0, 1'b0, 16'h9959, 1'b0, 1'b0, 1'b0));
        run_vec(mk("start_9959", 1'b0, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b0, 16'h9959, 1'b1, 1'b0, 1'b0));
        exp_t = 16'h9959;
        for (int i = 0; i < 59; i++) begin
            exp_t = bcd_dec(exp_t);
            run_vec(mk("count_99", 1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b1, exp_t, 1'b1, 1'b0, 1'b0));
        end
        run_vec(mk("tick_9859",  1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b1, 16'h9859, 1'b1, 1'b0, 1'b0));

        // Table-driven corner cases.
        for (int i = 0; i < tbl.size(); i++) begin
            run_vec(tbl[i]);
        end

        n_cmp++;
        if (exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL scoreboard_drain: got %0d left expected 0", exp_q.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
